// File: rtl/lpc_ringbuffer_if.sv
// rtl/lpc_ringbuffer_if.sv - RAM read port and outgoing byte stream of the frame ring buffer
interface lpc_ringbuffer_if #(
    parameter int SLOT_BITS = 5
);
    logic [SLOT_BITS+2:0] rd_addr;
    logic                 rd_en;
    logic [7:0]           rd_data;
    logic [7:0]           out_data;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output rd_addr,
        output rd_en,
        input  rd_data,
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  rd_addr,
        input  rd_en,
        output rd_data,
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/lpc_ringbuffer.sv
// rtl/lpc_ringbuffer.sv - slot ring for lpc2mem frames, drained byte-by-byte onto a valid/ready stream
module lpc_ringbuffer #(
    parameter int SLOT_BITS   = 5,
    parameter int FRAME_BYTES = 6,
    parameter int OVF_WIDTH   = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 lpc_frame_done,
    output logic [SLOT_BITS-1:0] target_addr,
    output logic [SLOT_BITS:0]   frames_pending,
    output logic [OVF_WIDTH-1:0] overflow_count,
    lpc_ringbuffer_if.master     bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LATCH = 2'd2,
        SEND  = 2'd3
    } state_t;

    // One slot is always kept free so the slot under write never aliases the slot being read.
    localparam logic [SLOT_BITS:0]   MAX_PENDING = {1'b0, {SLOT_BITS{1'b1}}};
    localparam logic [SLOT_BITS:0]   PTR_ONE     = {{SLOT_BITS{1'b0}}, 1'b1};
    localparam logic [OVF_WIDTH-1:0] OVF_ONE     = {{(OVF_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2:0]           LAST_IDX    = 3'(FRAME_BYTES - 1);

    state_t               state;
    state_t               state_nxt;
    logic [SLOT_BITS:0]   wptr;
    logic [SLOT_BITS:0]   rptr;
    logic [2:0]           idx;
    logic                 done_prev;
    logic                 commit;
    logic                 full;
    logic                 accept;
    logic                 last_byte;

    assign commit         = lpc_frame_done & ~done_prev;
    // Fullness is judged on the occupancy before any retirement in this same cycle.
    assign full           = (frames_pending >= MAX_PENDING);
    assign accept         = (state == SEND) & bus.out_ready;
    assign last_byte      = (idx == LAST_IDX);

    assign frames_pending = wptr - rptr;
    assign target_addr    = wptr[SLOT_BITS-1:0];
    assign bus.rd_addr    = {rptr[SLOT_BITS-1:0], idx};
    assign bus.rd_en      = (state == FETCH);

    // Writer side: edge-detect frame completion, advance the write slot or count a dropped frame.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            done_prev      <= 1'b1;
            wptr           <= '0;
            overflow_count <= '0;
        end else begin
            done_prev <= lpc_frame_done;
            if (commit) begin
                if (!full) begin
                    wptr <= wptr + PTR_ONE;
                end else if (overflow_count != {OVF_WIDTH{1'b1}}) begin
                    overflow_count <= overflow_count + OVF_ONE;
                end
            end
        end
    end

    // Reader state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Reader next state: one RAM read, one latch cycle, then hold until the sink takes the byte.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (frames_pending != '0) state_nxt = FETCH;
            FETCH:   state_nxt = LATCH;
            LATCH:   state_nxt = SEND;
            SEND:    if (accept) state_nxt = last_byte ? IDLE : FETCH;
            default: state_nxt = IDLE;
        endcase
    end

    // Reader datapath: byte index, read pointer and the registered stream byte.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rptr          <= '0;
            idx           <= '0;
            bus.out_data  <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    idx <= '0;
                end
                LATCH: begin
                    bus.out_data  <= bus.rd_data;
                    bus.out_valid <= 1'b1;
                end
                SEND: begin
                    if (accept) begin
                        bus.out_valid <= 1'b0;
                        if (last_byte) begin
                            rptr <= rptr + PTR_ONE;
                            idx  <= '0;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
